// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, parser states, bus field offsets.
// Also used by midi_note when it unpacks note_values/controller_values.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2,
        ST_EXEC
    } parse_state_t;

    localparam int unsigned NV_NOTE_LSB = 0;
    localparam int unsigned NV_VEL_LSB  = 8;
    localparam int unsigned CV_VAL_LSB  = 0;
    localparam int unsigned CV_NUM_LSB  = 8;

    function automatic logic [15:0] pack_bus(
        input logic [6:0]  hi,
        input logic [6:0]  lo,
        input int unsigned hi_lsb,
        input int unsigned lo_lsb
    );
        return (16'(hi) << hi_lsb) | (16'(lo) << lo_lsb);
    endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Byte-stream input, voice status and voice-bus outputs of the allocator.
// slave = allocator side, master = UART/voice side.
interface midi_voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    logic                  midi_byte_valid;
    logic [7:0]            midi_byte;
    logic [NUM_VOICES-1:0] voice_playing;
    logic [NUM_VOICES-1:0] update_note;
    logic                  update_all_notes;
    logic [15:0]           note_values;
    logic [15:0]           controller_values;
    logic                  steal_event;

    modport master (
        output midi_byte_valid, midi_byte, voice_playing,
        input  update_note, update_all_notes, note_values,
        input  controller_values, steal_event
    );

    modport slave (
        input  midi_byte_valid, midi_byte, voice_playing,
        output update_note, update_all_notes, note_values,
        output controller_values, steal_event
    );
endinterface

// File: rtl/midi_voice_table.sv
// Per-voice {allocated, note} registers with combinational match/free/steal
// lookup and a single write port; lowest index wins every lookup.
module midi_voice_table #(
    parameter int NUM_VOICES = 4,
    parameter int IW         = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            i_note,
    input  logic [NUM_VOICES-1:0] i_playing,
    input  logic                  i_wr_en,
    input  logic [IW-1:0]         i_wr_idx,
    input  logic                  i_wr_alloc,
    input  logic                  i_steal_adv,
    output logic                  o_match_hit,
    output logic [IW-1:0]         o_match_idx,
    output logic                  o_free_hit,
    output logic [IW-1:0]         o_free_idx,
    output logic [IW-1:0]         o_steal_idx
);

    logic [NUM_VOICES-1:0] r_alloc;
    logic [6:0]            r_note [NUM_VOICES];
    logic [IW-1:0]         r_steal;

    always_comb begin
        o_match_hit = 1'b0;
        o_match_idx = '0;
        o_free_hit  = 1'b0;
        o_free_idx  = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_alloc[i] && r_note[i] == i_note) begin
                o_match_hit = 1'b1;
                o_match_idx = IW'(i);
            end
            if (!r_alloc[i] && !i_playing[i]) begin
                o_free_hit = 1'b1;
                o_free_idx = IW'(i);
            end
        end
    end

    assign o_steal_idx = r_steal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alloc <= '0;
            r_steal <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
            end
        end else begin
            if (i_wr_en) begin
                r_alloc[i_wr_idx] <= i_wr_alloc;
                r_note[i_wr_idx]  <= i_note;
            end
            if (i_steal_adv) begin
                if (r_steal == IW'(NUM_VOICES - 1))
                    r_steal <= '0;
                else
                    r_steal <= r_steal + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI byte parser and note-to-voice allocator driving the midi_note buses.
// Define MIDI_OMNI_EN to accept all 16 channels instead of MIDI_CHANNEL only.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int         NUM_VOICES   = 4,
    parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    midi_voice_allocator_if.slave   bus
);

    localparam int IW = $clog2(NUM_VOICES);

    parse_state_t          r_state;
    logic [7:0]            r_status;
    logic [6:0]            r_d1;
    logic [6:0]            r_d2;
    logic [NUM_VOICES-1:0] r_update_note;
    logic                  r_update_all;
    logic [15:0]           r_note_values;
    logic [15:0]           r_ctrl_values;
    logic                  r_steal;

    logic [3:0]    w_hi;
    logic          w_ch_ok;
    logic          w_note_on;
    logic          w_note_off;
    logic          w_is_cc;
    logic          w_exec_msg;
    logic          w_one_byte;
    logic          w_rt;
    logic          w_sys;
    logic          w_stat;
    logic          w_match_hit;
    logic [IW-1:0] w_match_idx;
    logic          w_free_hit;
    logic [IW-1:0] w_free_idx;
    logic [IW-1:0] w_steal_idx;
    logic          w_wr_en;
    logic [IW-1:0] w_wr_idx;
    logic          w_wr_alloc;
    logic          w_steal_adv;

    assign w_hi       = r_status[7:4];
    assign w_note_on  = (w_hi == NOTE_ON) && (r_d2 != 7'd0);
    assign w_note_off = (w_hi == NOTE_OFF) || ((w_hi == NOTE_ON) && (r_d2 == 7'd0));
    assign w_is_cc    = (w_hi == CC);
    assign w_exec_msg = (w_hi == NOTE_OFF) || (w_hi == NOTE_ON) || (w_hi == CC);
    assign w_one_byte = (w_hi == PROG) || (w_hi == CH_AT);

`ifdef MIDI_OMNI_EN
    assign w_ch_ok = 1'b1;
`else
    assign w_ch_ok = (r_status[3:0] == MIDI_CHANNEL);
`endif

    assign w_rt   = (bus.midi_byte[7:3] == 5'b11111);
    assign w_sys  = (bus.midi_byte[7:3] == 5'b11110);
    assign w_stat = bus.midi_byte[7] && (bus.midi_byte[7:4] != 4'hF);

    midi_voice_table #(
        .NUM_VOICES (NUM_VOICES),
        .IW         (IW)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .i_note      (r_d1),
        .i_playing   (bus.voice_playing),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_wr_idx),
        .i_wr_alloc  (w_wr_alloc),
        .i_steal_adv (w_steal_adv),
        .o_match_hit (w_match_hit),
        .o_match_idx (w_match_idx),
        .o_free_hit  (w_free_hit),
        .o_free_idx  (w_free_idx),
        .o_steal_idx (w_steal_idx)
    );

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = '0;
        w_wr_alloc  = 1'b0;
        w_steal_adv = 1'b0;
        if (r_state == ST_EXEC && w_ch_ok) begin
            if (w_note_on) begin
                w_wr_en    = 1'b1;
                w_wr_alloc = 1'b1;
                unique case (1'b1)
                    w_match_hit: w_wr_idx = w_match_idx;
                    (!w_match_hit && w_free_hit): w_wr_idx = w_free_idx;
                    default: begin
                        w_wr_idx    = w_steal_idx;
                        w_steal_adv = 1'b1;
                    end
                endcase
            end else if (w_note_off && w_match_hit) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_match_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_status      <= '0;
            r_d1          <= '0;
            r_d2          <= '0;
            r_update_note <= '0;
            r_update_all  <= 1'b0;
            r_note_values <= '0;
            r_ctrl_values <= '0;
            r_steal       <= 1'b0;
        end else begin
            r_update_note <= '0;
            r_update_all  <= 1'b0;
            r_steal       <= 1'b0;
            if (r_state == ST_EXEC) begin
                r_state <= ST_DATA1;
                if (w_wr_en) begin
                    r_update_note <= {{(NUM_VOICES-1){1'b0}}, 1'b1} << w_wr_idx;
                    r_note_values <= pack_bus(w_note_on ? r_d2 : 7'd0, r_d1,
                                              NV_VEL_LSB, NV_NOTE_LSB);
                    r_steal       <= w_steal_adv;
                end else if (w_ch_ok && w_is_cc) begin
                    r_update_all  <= 1'b1;
                    r_ctrl_values <= pack_bus(r_d1, r_d2, CV_NUM_LSB, CV_VAL_LSB);
                end
            end else if (bus.midi_byte_valid) begin
                unique case (1'b1)
                    w_rt: ;
                    w_sys: begin
                        r_status <= '0;
                        r_state  <= ST_IDLE;
                    end
                    w_stat: begin
                        r_status <= bus.midi_byte;
                        r_state  <= ST_DATA1;
                    end
                    default: begin
                        unique case (r_state)
                            ST_DATA1: begin
                                if (!w_one_byte) begin
                                    r_d1    <= bus.midi_byte[6:0];
                                    r_state <= ST_DATA2;
                                end
                            end
                            ST_DATA2: begin
                                r_d2    <= bus.midi_byte[6:0];
                                r_state <= w_exec_msg ? ST_EXEC : ST_DATA1;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign bus.update_note       = r_update_note;
    assign bus.update_all_notes  = r_update_all;
    assign bus.note_values       = r_note_values;
    assign bus.controller_values = r_ctrl_values;
    assign bus.steal_event       = r_steal;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed-vector bench for midi_voice_allocator (4 voices, channel 0).
// Strobes are captured by a negedge monitor and checked after each message.
module tb_midi_voice_allocator;

    logic clk = 1'b0;
    logic reset = 1'b1;

    midi_voice_allocator_if #(.NUM_VOICES(4)) bus ();

    midi_voice_allocator #(
        .NUM_VOICES   (4),
        .MIDI_CHANNEL (4'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int          n_upd;
    int          n_all;
    int          n_stl;
    int          n_hot;
    logic [3:0]  l_upd;
    logic [15:0] l_nv;
    logic [15:0] l_cv;

    always @(negedge clk) begin
        if (bus.update_note != 4'b0) begin
            n_upd++;
            l_upd = bus.update_note;
            l_nv  = bus.note_values;
            if (!$onehot(bus.update_note)) n_hot++;
        end
        if (bus.update_all_notes) begin
            n_all++;
            l_cv = bus.controller_values;
        end
        if (bus.steal_event) n_stl++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_upd = 0;
        n_all = 0;
        n_stl = 0;
        l_upd = '0;
        l_nv  = '0;
        l_cv  = '0;
    endtask

    task automatic tx(input logic [7:0] b);
        @(negedge clk);
        bus.midi_byte_valid = 1'b1;
        bus.midi_byte       = b;
        @(negedge clk);
        bus.midi_byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic msg3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        clr();
        tx(a);
        tx(b);
        tx(c);
        settle();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_upd"}, 32'(bus.update_note), 32'h0);
        chk({tag, "_nv"}, 32'(bus.note_values), 32'h0);
        chk({tag, "_cv"}, 32'(bus.controller_values), 32'h0);
        chk({tag, "_all_stl"}, {30'b0, bus.update_all_notes, bus.steal_event}, 32'h0);
    endtask

    task automatic chk_note(input string tag, input logic [3:0] upd, input logic [15:0] nv,
                            input int stl);
        chk({tag, "_n"}, 32'(n_upd), 32'd1);
        chk({tag, "_upd"}, 32'(l_upd), 32'(upd));
        chk({tag, "_nv"}, 32'(l_nv), 32'(nv));
        chk({tag, "_stl"}, 32'(n_stl), 32'(stl));
    endtask

    task automatic chk_none(input string tag);
        chk({tag, "_n"}, 32'(n_upd), 32'd0);
        chk({tag, "_all"}, 32'(n_all), 32'd0);
    endtask

    initial begin
        n_hot               = 0;
        bus.midi_byte_valid = 1'b0;
        bus.midi_byte       = 8'h00;
        bus.voice_playing   = 4'b0000;
        clr();
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        msg3(8'h90, 8'h32, 8'h7F);
        chk_note("on32", 4'b0001, 16'h7F32, 0);

        clr();
        tx(8'h32);
        tx(8'h00);
        settle();
        chk_note("rs_off32", 4'b0001, 16'h0032, 0);

        msg3(8'h90, 8'h33, 8'h10);
        chk_note("reuse_v0", 4'b0001, 16'h1033, 0);

        msg3(8'hB0, 8'h07, 8'h40);
        chk("cc_all", 32'(n_all), 32'd1);
        chk("cc_val", 32'(l_cv), 32'h0740);
        chk("cc_upd", 32'(n_upd), 32'd0);

        msg3(8'h80, 8'h45, 8'h00);
        chk_none("off_unheld");

        pulse_reset();
        chk_zero("rst2");

        msg3(8'h90, 8'h3C, 8'h7F);
        chk_note("a60", 4'b0001, 16'h7F3C, 0);
        msg3(8'h90, 8'h3D, 8'h7F);
        chk_note("a61", 4'b0010, 16'h7F3D, 0);
        msg3(8'h90, 8'h3E, 8'h7F);
        chk_note("a62", 4'b0100, 16'h7F3E, 0);
        msg3(8'h90, 8'h3F, 8'h7F);
        chk_note("a63", 4'b1000, 16'h7F3F, 0);
        bus.voice_playing = 4'b1111;
        msg3(8'h90, 8'h40, 8'h7F);
        chk_note("steal64", 4'b0001, 16'h7F40, 1);
        msg3(8'h90, 8'h41, 8'h7F);
        chk_note("steal65", 4'b0010, 16'h7F41, 1);
        msg3(8'h90, 8'h3E, 8'h20);
        chk_note("retrig62", 4'b0100, 16'h203E, 0);
        bus.voice_playing = 4'b0000;
        msg3(8'h90, 8'h50, 8'h7F);
        chk_note("reserved", 4'b0100, 16'h7F50, 1);

        pulse_reset();

        clr();
        tx(8'h90);
        tx(8'h3C);
        tx(8'hF8);
        tx(8'h64);
        settle();
        chk_note("rt_skip", 4'b0001, 16'h643C, 0);

        msg3(8'h91, 8'h3C, 8'h64);
`ifdef MIDI_OMNI_EN
        chk_note("ch1", 4'b0001, 16'h643C, 0);
`else
        chk_none("ch1");
`endif

        msg3(8'h80, 8'h3C, 8'h40);
        chk_note("off80", 4'b0001, 16'h003C, 0);

        clr();
        tx(8'h3C);
        tx(8'h40);
        settle();
        chk_none("off_again");

        clr();
        tx(8'hF0);
        tx(8'h01);
        tx(8'h02);
        tx(8'hF7);
        tx(8'h3C);
        tx(8'h7F);
        settle();
        chk_none("sysex");

        clr();
        tx(8'hC0);
        tx(8'h05);
        tx(8'h06);
        settle();
        chk_none("prog");

        msg3(8'h90, 8'h10, 8'h20);
        chk_note("after_prog", 4'b0001, 16'h2010, 0);

        msg3(8'hA0, 8'h10, 8'h20);
        chk_none("polyat");

        clr();
        tx(8'h90);
        tx(8'h11);
        tx(8'hB0);
        tx(8'h07);
        tx(8'h05);
        settle();
        chk("partial_upd", 32'(n_upd), 32'd0);
        chk("partial_all", 32'(n_all), 32'd1);
        chk("partial_cv", 32'(l_cv), 32'h0705);

        clr();
        tx(8'h90);
        tx(8'h22);
        pulse_reset();
        chk_zero("rst_mid");
        tx(8'h7F);
        tx(8'h23);
        settle();
        chk_none("rst_tail");

        chk("onehot", 32'(n_hot), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
